// File: rtl/sdram_memtest.sv
// -----------------------------------------------------------------------------
// sdram_memtest
//   Built-in memory test engine placed in front of sdram_controller's host
//   port. On start it waits for controller configuration, then runs two data
//   patterns over a word range. Each pattern writes the whole range and then
//   reads it back and compares every word. The first failure, whether a data
//   mismatch or a missing m_compl, is reported and ends the test.
//
//   Patterns (a = word address):
//     P0 : {2'b00,a} + 1
//     P1 : a[0] ? 32'h55aaaa55 : 32'haa5555aa
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle pulse, accepted in IDLE or DONE
//   busy / done      test running / test finished (held until next start)
//   pass, timed_out  result flags, valid while done=1
//   err_addr         word address of the first failure
//   err_expected     expected data at err_addr
//   err_got          data read at err_addr (0 on timeout)
//   m_cs, m_addr, m_wr_en, m_bytesel, m_wdata   controller host request
//   m_rdata, m_compl, m_config_done             controller host response
// -----------------------------------------------------------------------------
module sdram_memtest #(
   parameter logic [29:0] START_ADDR = 30'h0,
   parameter int unsigned NUM_WORDS  = 16384,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timed_out,
   output logic [29:0] err_addr,
   output logic [31:0] err_expected,
   output logic [31:0] err_got,
   output logic        m_cs,
   output logic [29:0] m_addr,
   output logic        m_wr_en,
   output logic [3:0]  m_bytesel,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_compl,
   input  logic        m_config_done
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_CFG = 3'd1;
   localparam logic [2:0] S_WR       = 3'd2;
   localparam logic [2:0] S_WR_GAP   = 3'd3;
   localparam logic [2:0] S_RD       = 3'd4;
   localparam logic [2:0] S_RD_GAP   = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   // Last address of the range, 30-bit wrap intended.
   localparam logic [29:0] LAST_ADDR = START_ADDR + 30'(NUM_WORDS - 1);

   // The wait counter only ever holds 0..TIMEOUT-1.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   function automatic logic [31:0] pattern(input logic p, input logic [29:0] a);
      if (!p) return {2'b00, a} + 32'd1;
      else    return a[0] ? 32'h55aaaa55 : 32'haa5555aa;
   endfunction

   logic [2:0]    state_q, state_d;
   logic          pat_q, pat_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          tmo_q, tmo_d;
   logic [29:0]   err_addr_q, err_addr_d;
   logic [31:0]   err_exp_q, err_exp_d;
   logic [31:0]   err_got_q, err_got_d;
   logic          cs_q, cs_d;
   logic [29:0]   addr_q, addr_d;
   logic          wr_en_q, wr_en_d;
   logic [3:0]    bsel_q, bsel_d;
   logic [31:0]   wdata_q, wdata_d;

   // Requests to start a new access, resolved after the state decode.
   logic          launch;
   logic          launch_wr;
   logic          nxt_pat;
   logic [29:0]   nxt_addr;

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      tmo_d      = tmo_q;
      err_addr_d = err_addr_q;
      err_exp_d  = err_exp_q;
      err_got_d  = err_got_q;
      cs_d       = cs_q;
      addr_d     = addr_q;
      wr_en_d    = wr_en_q;
      bsel_d     = bsel_q;
      wdata_d    = wdata_q;
      launch     = 1'b0;
      launch_wr  = 1'b0;
      nxt_pat    = pat_q;
      nxt_addr   = addr_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_WAIT_CFG;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               tmo_d      = 1'b0;
               err_addr_d = '0;
               err_exp_d  = '0;
               err_got_d  = '0;
            end
         end

         S_WAIT_CFG: begin
            if (m_config_done) begin
               nxt_pat   = 1'b0;
               nxt_addr  = START_ADDR;
               launch    = 1'b1;
               launch_wr = 1'b1;
            end
         end

         S_WR, S_RD: begin
            if (m_compl) begin
               // Completion wins even on the cycle the counter expires.
               cs_d   = 1'b0;
               bsel_d = '0;
               if (state_q == S_RD && m_rdata != wdata_q) begin
                  state_d    = S_DONE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  pass_d     = 1'b0;
                  err_addr_d = addr_q;
                  err_exp_d  = wdata_q;
                  err_got_d  = m_rdata;
               end else begin
                  state_d = (state_q == S_WR) ? S_WR_GAP : S_RD_GAP;
               end
            end else if (cnt_q == CNT_LAST) begin
               cs_d       = 1'b0;
               bsel_d     = '0;
               state_d    = S_DONE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               pass_d     = 1'b0;
               tmo_d      = 1'b1;
               err_addr_d = addr_q;
               err_exp_d  = wdata_q;
               err_got_d  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_WR_GAP: begin
            launch = 1'b1;
            if (addr_q == LAST_ADDR) begin
               nxt_addr  = START_ADDR;
               launch_wr = 1'b0;
            end else begin
               nxt_addr  = addr_q + 30'd1;
               launch_wr = 1'b1;
            end
         end

         S_RD_GAP: begin
            if (addr_q == LAST_ADDR) begin
               if (!pat_q) begin
                  nxt_pat   = 1'b1;
                  nxt_addr  = START_ADDR;
                  launch    = 1'b1;
                  launch_wr = 1'b1;
               end else begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end
            end else begin
               nxt_addr  = addr_q + 30'd1;
               launch    = 1'b1;
               launch_wr = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         state_d = launch_wr ? S_WR : S_RD;
         pat_d   = nxt_pat;
         addr_d  = nxt_addr;
         wdata_d = pattern(nxt_pat, nxt_addr);
         cs_d    = 1'b1;
         bsel_d  = '1;
         wr_en_d = launch_wr;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pat_q      <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         tmo_q      <= 1'b0;
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_got_q  <= '0;
         cs_q       <= 1'b0;
         addr_q     <= '0;
         wr_en_q    <= 1'b0;
         bsel_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         tmo_q      <= tmo_d;
         err_addr_q <= err_addr_d;
         err_exp_q  <= err_exp_d;
         err_got_q  <= err_got_d;
         cs_q       <= cs_d;
         addr_q     <= addr_d;
         wr_en_q    <= wr_en_d;
         bsel_q     <= bsel_d;
         wdata_q    <= wdata_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timed_out    = tmo_q;
   assign err_addr     = err_addr_q;
   assign err_expected = err_exp_q;
   assign err_got      = err_got_q;
   assign m_cs         = cs_q;
   assign m_addr       = addr_q;
   assign m_wr_en      = wr_en_q;
   assign m_bytesel    = bsel_q;
   assign m_wdata      = wdata_q;

endmodule

// File: tb/tb_sdram_memtest.sv
// -----------------------------------------------------------------------------
// tb_sdram_memtest
//   Two engines (START_ADDR 0 and 30'h3ffffffc, 8 words, TIMEOUT 15), each
//   in front of a small memory model that answers m_compl three cycles after
//   m_cs rises. The model can drop the completion of, or corrupt the readback
//   of, a chosen transaction index, and logs every issued access.
// -----------------------------------------------------------------------------
module tb_sdram_memtest;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg;
   logic        start     [2];
   logic        busy      [2];
   logic        done      [2];
   logic        pass      [2];
   logic        tmo       [2];
   logic [29:0] err_addr  [2];
   logic [31:0] err_exp   [2];
   logic [31:0] err_got   [2];
   logic        cs        [2];
   logic [29:0] addr      [2];
   logic        wr        [2];
   logic [3:0]  bsel      [2];
   logic [31:0] wdata     [2];
   logic [31:0] rdata     [2];
   logic        compl     [2];

   always #5 clk = ~clk;

   sdram_memtest #(.START_ADDR(30'h0), .NUM_WORDS(8), .TIMEOUT(15)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timed_out(tmo[0]),
      .err_addr(err_addr[0]), .err_expected(err_exp[0]), .err_got(err_got[0]),
      .m_cs(cs[0]), .m_addr(addr[0]), .m_wr_en(wr[0]), .m_bytesel(bsel[0]),
      .m_wdata(wdata[0]), .m_rdata(rdata[0]), .m_compl(compl[0]),
      .m_config_done(cfg)
   );

   sdram_memtest #(.START_ADDR(30'h3ffffffc), .NUM_WORDS(8), .TIMEOUT(15)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timed_out(tmo[1]),
      .err_addr(err_addr[1]), .err_expected(err_exp[1]), .err_got(err_got[1]),
      .m_cs(cs[1]), .m_addr(addr[1]), .m_wr_en(wr[1]), .m_bytesel(bsel[1]),
      .m_wdata(wdata[1]), .m_rdata(rdata[1]), .m_compl(compl[1]),
      .m_config_done(cfg)
   );

   // ---------------- memory model / monitor ----------------
   logic        mdl_clr;
   int          drop_txn    [2];
   int          corrupt_txn [2];
   int          nissue      [2];
   int          cs_len      [2];
   int          last_len    [2];
   int          gap_err     [2];
   logic        prev_compl  [2];
   logic [31:0] mem         [2][8];
   logic [29:0] log_addr    [2][64];
   logic        log_wr      [2][64];
   logic [31:0] log_data    [2][64];

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mdl_clr) begin
            nissue[g]     <= 0;
            cs_len[g]     <= 0;
            last_len[g]   <= 0;
            gap_err[g]    <= 0;
            prev_compl[g] <= 1'b0;
            compl[g]      <= 1'b0;
            rdata[g]      <= 32'h0;
         end else begin
            prev_compl[g] <= compl[g];
            if (prev_compl[g] && cs[g]) gap_err[g] <= gap_err[g] + 1;
            if (!cs[g]) begin
               if (cs_len[g] != 0) last_len[g] <= cs_len[g];
               cs_len[g] <= 0;
               compl[g]  <= 1'b0;
            end else begin
               cs_len[g] <= cs_len[g] + 1;
               if (cs_len[g] == 0) begin
                  if (nissue[g] < 64) begin
                     log_addr[g][nissue[g]] <= addr[g];
                     log_wr[g][nissue[g]]   <= wr[g];
                     log_data[g][nissue[g]] <= wdata[g];
                  end
                  nissue[g] <= nissue[g] + 1;
               end
               if (compl[g]) begin
                  compl[g] <= 1'b0;
               end else if (cs_len[g] == 2 && (nissue[g] - 1) != drop_txn[g]) begin
                  compl[g] <= 1'b1;
                  if (wr[g]) mem[g][addr[g][2:0]] <= wdata[g];
                  else rdata[g] <= mem[g][addr[g][2:0]] ^
                                   (((nissue[g] - 1) == corrupt_txn[g]) ? 32'h10 : 32'h0);
               end
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start(input int g);
      start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
   endtask

   task automatic clear_model();
      mdl_clr = 1'b1;
      tick();
      mdl_clr = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget);
      int n = 0;
      while (!done[g] && n < budget) begin
         tick();
         n++;
      end
      chk("done_within_budget", done[g], 1'b1);
   endtask

   function automatic logic [29:0] base_of(input int g);
      return (g == 0) ? 30'h0 : 30'h3ffffffc;
   endfunction

   function automatic logic [31:0] exp_data(input int p, input logic [29:0] a);
      if (p == 0) return {2'b00, a} + 32'd1;
      return a[0] ? 32'h55aaaa55 : 32'haa5555aa;
   endfunction

   // ---------------- scenario table ----------------
   typedef struct {
      int          g;
      int          drop;
      int          corrupt;
      int          extra_start;
      logic        exp_pass;
      logic        exp_to;
      logic [29:0] exp_eaddr;
      logic [31:0] exp_eexp;
      logic [31:0] exp_egot;
      int          exp_nissue;
      int          exp_len;
   } vec_t;

   vec_t vt [5];

   initial begin
      vt[0] = '{g:0, drop:-1, corrupt:-1, extra_start:0, exp_pass:1'b1, exp_to:1'b0,
                exp_eaddr:30'h0, exp_eexp:32'h0, exp_egot:32'h0, exp_nissue:32, exp_len:4};
      vt[1] = '{g:0, drop:-1, corrupt:13, extra_start:0, exp_pass:1'b0, exp_to:1'b0,
                exp_eaddr:30'h5, exp_eexp:32'h6, exp_egot:32'h16, exp_nissue:14, exp_len:4};
      vt[2] = '{g:0, drop:2, corrupt:-1, extra_start:0, exp_pass:1'b0, exp_to:1'b1,
                exp_eaddr:30'h2, exp_eexp:32'h3, exp_egot:32'h0, exp_nissue:3, exp_len:15};
      vt[3] = '{g:1, drop:-1, corrupt:-1, extra_start:1, exp_pass:1'b1, exp_to:1'b0,
                exp_eaddr:30'h0, exp_eexp:32'h0, exp_egot:32'h0, exp_nissue:32, exp_len:4};
      vt[4] = '{g:0, drop:-1, corrupt:-1, extra_start:0, exp_pass:1'b1, exp_to:1'b0,
                exp_eaddr:30'h0, exp_eexp:32'h0, exp_egot:32'h0, exp_nissue:32, exp_len:4};

      rst_n    = 1'b0;
      cfg      = 1'b0;
      start[0] = 1'b0;
      start[1] = 1'b0;
      mdl_clr  = 1'b1;
      for (int g = 0; g < 2; g++) begin
         drop_txn[g]    = -1;
         corrupt_txn[g] = -1;
      end
      repeat (3) tick();

      // Reset state
      chk("rst_busy",    busy[0], 1'b0);
      chk("rst_done",    done[0], 1'b0);
      chk("rst_pass",    pass[0], 1'b0);
      chk("rst_tmo",     tmo[0], 1'b0);
      chk("rst_eaddr",   err_addr[0], 30'h0);
      chk("rst_eexp",    err_exp[0], 32'h0);
      chk("rst_egot",    err_got[0], 32'h0);
      chk("rst_cs",      cs[0], 1'b0);
      chk("rst_addr",    addr[0], 30'h0);
      chk("rst_wr",      wr[0], 1'b0);
      chk("rst_bsel",    bsel[0], 4'h0);
      chk("rst_wdata",   wdata[0], 32'h0);
      chk("rst_cs1",     cs[1], 1'b0);
      rst_n   = 1'b1;
      mdl_clr = 1'b0;
      repeat (2) tick();
      chk("idle_busy", busy[0], 1'b0);

      // No config yet: engine parks in WAIT_CFG with no access
      pulse_start(0);
      chk("cfgwait_busy0", busy[0], 1'b1);
      repeat (20) tick();
      chk("cfgwait_busy", busy[0], 1'b1);
      chk("cfgwait_cs", cs[0], 1'b0);
      chk("cfgwait_issued", nissue[0], 0);
      chk("cfgwait_done", done[0], 1'b0);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      cfg = 1'b1;

      // Table-driven scenarios
      for (int i = 0; i < 5; i++) begin
         int g;
         g = vt[i].g;
         drop_txn[g]    = vt[i].drop;
         corrupt_txn[g] = vt[i].corrupt;
         clear_model();
         pulse_start(g);
         chk("start_busy",  busy[g], 1'b1);
         chk("start_done",  done[g], 1'b0);
         chk("start_eaddr", err_addr[g], 30'h0);
         chk("start_tmo",   tmo[g], 1'b0);
         if (vt[i].extra_start != 0) begin
            repeat (30) tick();
            pulse_start(g);
         end
         wait_done(g, 3000);
         repeat (10) tick();
         chk("end_done",   done[g], 1'b1);
         chk("end_busy",   busy[g], 1'b0);
         chk("end_pass",   pass[g], vt[i].exp_pass);
         chk("end_tmo",    tmo[g], vt[i].exp_to);
         chk("end_eaddr",  err_addr[g], vt[i].exp_eaddr);
         chk("end_eexp",   err_exp[g], vt[i].exp_eexp);
         chk("end_egot",   err_got[g], vt[i].exp_egot);
         chk("end_issued", nissue[g], vt[i].exp_nissue);
         chk("end_cs",     cs[g], 1'b0);
         chk("last_cs_len", last_len[g], vt[i].exp_len);
         chk("gap_violations", gap_err[g], 0);
         chk("log0_addr", log_addr[g][0], base_of(g));
         chk("log0_data", log_data[g][0], exp_data(0, base_of(g)));
         if (vt[i].exp_pass) begin
            for (int j = 0; j < 32; j++) begin
               logic [29:0] a;
               a = base_of(g) + 30'(j % 8);
               chk("log_addr", log_addr[g][j], a);
               chk("log_wr",   log_wr[g][j], ((j % 16) < 8) ? 1'b1 : 1'b0);
               chk("log_data", log_data[g][j], exp_data(j / 16, a));
            end
         end
      end

      // Reset during a P1 read, then rerun
      drop_txn[0]    = -1;
      corrupt_txn[0] = -1;
      clear_model();
      pulse_start(0);
      begin
         int n = 0;
         while (!(nissue[0] >= 25 && cs[0]) && n < 3000) begin
            tick();
            n++;
         end
      end
      chk("midrd_reached", nissue[0], 25);
      chk("midrd_is_read", wr[0], 1'b0);
      chk("midrd_addr", addr[0], 30'h0);
      rst_n = 1'b0;
      tick();
      chk("midrd_rst_cs",   cs[0], 1'b0);
      chk("midrd_rst_bsel", bsel[0], 4'h0);
      chk("midrd_rst_busy", busy[0], 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("midrd_no_more", nissue[0], 25);
      clear_model();
      pulse_start(0);
      wait_done(0, 3000);
      chk("rerun_pass",   pass[0], 1'b1);
      chk("rerun_issued", nissue[0], 32);
      chk("rerun_eaddr",  err_addr[0], 30'h0);
      chk("rerun_addr0",  log_addr[0][0], 30'h0);
      chk("rerun_data0",  log_data[0][0], 32'h1);
      chk("rerun_p1wr",   log_data[0][17], 32'h55aaaa55);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/sdram_memtest.md
Name: sdram_memtest

Overview:
Synthesizable built-in memory test engine that sits directly upstream of sdram_controller and drives its host port.
- On start, it runs two patterns in order. Each pattern writes a word range, then reads the range back and compares every word.
- Reports pass/fail plus the first failing address, expected data and read data.
- Used for board bring-up and power-on self test ahead of the CPU bus mux.

Parameters:
START_ADDR, 30'h0, first word address tested (h_addr[31:2] units).
NUM_WORDS, 16384, number of 32-bit words per pass; must be >= 2.
TIMEOUT, 1023, max cycles to wait for m_compl per transaction before failing.

Ports:
clk  in  1  system clock, same clock as sdram_controller.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; starts a test when idle.
busy  out  1  test in progress.
done  out  1  test finished (pass or fail); held until next start.
pass  out  1  valid when done=1.
timed_out  out  1  failure was a missing m_compl.
err_addr  out  30  word address of first failure.
err_expected  out  32  expected data at err_addr.
err_got  out  32  data read at err_addr (0 on timeout).
m_cs  out  1  to controller cs.
m_addr  out  30  to controller h_addr.
m_wr_en  out  1  1=write, 0=read.
m_bytesel  out  4  4'b1111 during a transaction, else 4'b0000.
m_wdata  out  32  write data.
m_rdata  in  32  read data from controller.
m_compl  in  1  transaction complete.
m_config_done  in  1  controller init/config complete.

Behaviour:
- Synchronous reset (rst_n low at clk edge) clears all state:
  - state=IDLE; busy/done/pass/timed_out=0.
  - err_* = 0; m_cs=0, m_bytesel=0, m_wr_en=0, m_addr=0, m_wdata=0.
  - Reset mid-transaction aborts it: m_cs drops at that edge, and no further access is issued.
- All outputs are registered.
- Patterns, with a = word address:
  - P0: data = {2'b00,a} + 32'd1, modulo 2^32.
  - P1: a[0]=0 -> 32'haa5555aa; a[0]=1 -> 32'h55aaaa55.
- States: IDLE -> WAIT_CFG -> WR -> WR_GAP -> RD -> RD_GAP -> (next pattern or DONE).
- IDLE:
  - start=1 -> WAIT_CFG; busy=1 the next cycle; done/pass/timed_out/err_* cleared.
  - start while busy or in DONE-but-busy is ignored; start in DONE restarts the test.
- WAIT_CFG: stays until m_config_done=1, then pattern=P0, a=START_ADDR, -> WR.
- WR / RD:
  - m_cs=1, m_bytesel=4'b1111, m_wr_en=1 (WR) or 0 (RD).
  - m_addr=a; m_wdata=pattern(a), also driven in RD so it is stable.
  - All held stable until m_compl=1 is sampled.
  - On that edge: m_cs=0, m_bytesel=0, then go to *_GAP. This guarantees one idle cycle between transactions.
  - In RD, m_rdata is sampled on the m_compl edge. A mismatch latches err_addr=a, err_expected=pattern(a), err_got=m_rdata, then -> DONE with pass=0.
- *_GAP:
  - If a == START_ADDR+NUM_WORDS-1: a=START_ADDR and WR_GAP->RD, or RD_GAP->(P0 ? WR with P1 : DONE with pass=1).
  - Otherwise a=a+1 (30-bit wrap permitted) and return to WR/RD.
- Timeout:
  - A cycle counter resets at entry to WR/RD.
  - If it reaches TIMEOUT with no m_compl: m_cs=0, timed_out=1, err_addr=a, err_expected=pattern(a), err_got=0 -> DONE, pass=0.
  - m_compl on the same cycle the count reaches TIMEOUT counts as success.
- DONE: busy=0, done=1; outputs hold until start or reset.
- m_compl outside WR/RD is ignored.
- m_config_done dropping after WAIT_CFG is ignored.
- Transaction count on success = 4*NUM_WORDS: write+read for each of 2 patterns.

Test Plan:
- Reset then idle: all outputs 0; with m_config_done=0 a start holds WAIT_CFG and m_cs=0 indefinitely.
- Happy path, NUM_WORDS=8, START_ADDR=0, ideal memory model with m_compl 3 cycles after m_cs:
  - 32 transactions; first write addr 0 data 1; P1 write at addr 1 data 55aaaa55.
  - Ends done=1, pass=1, busy=0; m_cs low >=1 cycle between every transaction.
- Corruption: model flips bit 4 of word 5 on P0 readback -> done=1, pass=0, err_addr=5, err_expected=6, err_got=32'h16; no further transaction issued.
- Timeout, TIMEOUT=15: model never asserts m_compl on the 3rd write -> m_cs drops after 15 cycles, timed_out=1, err_addr=2, err_expected=3, err_got=0.
- Reset mid-read of P1 then start again: m_cs low at the reset edge; rerun passes from P0 addr 0 with err_* cleared.
- start pulsed while busy and START_ADDR=30'h3ffffffc with NUM_WORDS=8: the extra start is ignored; addresses wrap 3fffffff->0 and the test passes.
